// File: rtl/cand_pkg.sv
// Shared definitions for the candidate bank controller.
// CAND_DEDUP_EN adds the LOOKUP state used by the duplicate-ID insert path.
package cand_pkg;

  localparam int unsigned MAX_CAND_DEF = 8;
  localparam int unsigned ENTRY_STRIDE = 2;
  localparam int unsigned IDX_W        = 4;

  localparam int unsigned ID_MSB  = 15;
  localparam int unsigned ID_LSB  = 8;
  localparam int unsigned FIT_MSB = 7;
  localparam int unsigned FIT_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCAN,
    DONE
`ifdef CAND_DEDUP_EN
    , LOOKUP
`endif
  } state_t;

  // Bank index of entry k (each entry occupies two byte slots).
  function automatic logic [IDX_W-1:0] entry_index(input logic [IDX_W-1:0] k);
    return IDX_W'(k * ENTRY_STRIDE);
  endfunction

endpackage

// File: rtl/cand_bank_ctrl_if.sv
// Request/status and bank-side signals of the candidate bank controller.
// slave: the controller; master: the requester that also models the bank.
interface cand_bank_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             ins_valid;
  logic             ins_ready;
  logic [7:0]       ins_id;
  logic [7:0]       ins_fit;
  logic             ins_drop;
  logic             scan_start;
  logic             scan_busy;
  logic             scan_done;
  logic             best_valid;
  logic [7:0]       best_id;
  logic [7:0]       best_fit;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             mem_wr_en;
  logic [3:0]       mem_index;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;

  modport master (
    output ins_valid, ins_id, ins_fit, scan_start, clear, mem_rdata,
    input  ins_ready, ins_drop, scan_busy, scan_done, best_valid, best_id,
           best_fit, count, full, empty, mem_wr_en, mem_index, mem_wdata
  );

  modport slave (
    input  ins_valid, ins_id, ins_fit, scan_start, clear, mem_rdata,
    output ins_ready, ins_drop, scan_busy, scan_done, best_valid, best_id,
           best_fit, count, full, empty, mem_wr_en, mem_index, mem_wdata
  );
endinterface

// File: rtl/cand_bank_ctrl_max_track.sv
// Running-maximum register for the best-candidate scan.
// Strict greater-than keeps the lowest index on fitness ties.
module cand_max_track
  import cand_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        init,
  input  logic        en,
  input  logic        first,
  input  logic [15:0] entry,
  output logic [7:0]  best_id,
  output logic [7:0]  best_fit
);

  logic [7:0] fit_in;
  assign fit_in = entry[FIT_MSB:FIT_LSB];

  // Load the first entry unconditionally, later ones only if strictly better.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      best_id  <= '0;
      best_fit <= '0;
    end else if (init) begin
      best_id  <= '0;
      best_fit <= '0;
    end else if (en && (first || (fit_in > best_fit))) begin
      best_id  <= entry[ID_MSB:ID_LSB];
      best_fit <= fit_in;
    end
  end

endmodule

// File: rtl/cand_bank_ctrl.sv
// Candidate list controller: sole writer of the 16-bit candidate bank.
// Appends {id,fit} entries, clears the list and scans for the best fitness.
// Optional CAND_DEDUP_EN: inserts first look up the ID and overwrite on match.
module cand_bank_ctrl
  import cand_pkg::*;
#(
  parameter int unsigned MAX_CAND = MAX_CAND_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic           clk,
  input  logic           nrst,
  cand_bank_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CAND);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [7:0]       id_q, id_nxt;
  logic [7:0]       fit_q, fit_nxt;
  logic             best_valid, best_valid_nxt;
  logic             track_init, track_en;
  logic             full, last;
`ifdef CAND_DEDUP_EN
  logic             ovw, ovw_nxt, match, drop;
`endif

  assign full = (count == CNT_MAX);
  assign last = (ptr == count - CNT_ONE);

`ifdef CAND_DEDUP_EN
  assign match = (count != '0) && (bus.mem_rdata[ID_MSB:ID_LSB] == id_q);
  assign bus.ins_ready = (state == IDLE) && !bus.clear && !bus.scan_start;
  assign bus.ins_drop  = drop;
`else
  assign bus.ins_ready = (state == IDLE) && !full && !bus.clear && !bus.scan_start;
  assign bus.ins_drop  = 1'b0;
`endif

  assign bus.scan_busy  = (state == SCAN);
  assign bus.scan_done  = (state == DONE);
  assign bus.best_valid = best_valid;
  assign bus.count      = count;
  assign bus.full       = full;
  assign bus.empty      = (count == '0);
  assign bus.mem_wr_en  = (state == WRITE) && !bus.clear;
  assign bus.mem_wdata  = (state == WRITE) ? {id_q, fit_q} : '0;

  // Bank address: write slot in WRITE, read pointer while scanning/looking up.
  always_comb begin
    bus.mem_index = '0;
    if (state == WRITE) begin
      bus.mem_index = entry_index(IDX_W'(wr_ptr));
    end else if (state == SCAN) begin
      bus.mem_index = entry_index(IDX_W'(ptr));
    end
`ifdef CAND_DEDUP_EN
    else if (state == LOOKUP) begin
      bus.mem_index = entry_index(IDX_W'(ptr));
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers follow the next-values chosen by the FSM logic.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count      <= '0;
      ptr        <= '0;
      wr_ptr     <= '0;
      id_q       <= '0;
      fit_q      <= '0;
      best_valid <= 1'b0;
`ifdef CAND_DEDUP_EN
      ovw        <= 1'b0;
`endif
    end else begin
      count      <= count_nxt;
      ptr        <= ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      id_q       <= id_nxt;
      fit_q      <= fit_nxt;
      best_valid <= best_valid_nxt;
`ifdef CAND_DEDUP_EN
      ovw        <= ovw_nxt;
`endif
    end
  end

  // Next-state and datapath control; clear overrides every state.
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    ptr_nxt        = ptr;
    wr_ptr_nxt     = wr_ptr;
    id_nxt         = id_q;
    fit_nxt        = fit_q;
    best_valid_nxt = best_valid;
    track_init     = 1'b0;
    track_en       = 1'b0;
`ifdef CAND_DEDUP_EN
    ovw_nxt        = ovw;
    drop           = 1'b0;
`endif
    if (bus.clear) begin
      state_nxt      = IDLE;
      count_nxt      = '0;
      best_valid_nxt = 1'b0;
      track_init     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.scan_start) begin
            track_init = 1'b1;
            if (count == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt      = SCAN;
              ptr_nxt        = '0;
              best_valid_nxt = 1'b0;
            end
          end else if (bus.ins_valid && bus.ins_ready) begin
            id_nxt         = bus.ins_id;
            fit_nxt        = bus.ins_fit;
            best_valid_nxt = 1'b0;
            ptr_nxt        = '0;
            wr_ptr_nxt     = count;
`ifdef CAND_DEDUP_EN
            state_nxt      = LOOKUP;
`else
            state_nxt      = WRITE;
`endif
          end
        end
        WRITE: begin
          state_nxt = IDLE;
`ifdef CAND_DEDUP_EN
          if (!ovw) count_nxt = count + CNT_ONE;
`else
          count_nxt = count + CNT_ONE;
`endif
        end
        SCAN: begin
          track_en = 1'b1;
          if (last) begin
            state_nxt      = DONE;
            best_valid_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + CNT_ONE;
          end
        end
        DONE: state_nxt = IDLE;
`ifdef CAND_DEDUP_EN
        LOOKUP: begin
          if (match) begin
            wr_ptr_nxt = ptr;
            ovw_nxt    = 1'b1;
            state_nxt  = WRITE;
          end else if ((count == '0) || last) begin
            if (!full) begin
              wr_ptr_nxt = count;
              ovw_nxt    = 1'b0;
              state_nxt  = WRITE;
            end else begin
              drop      = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            ptr_nxt = ptr + CNT_ONE;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  cand_max_track u_track (
    .clk      (clk),
    .nrst     (nrst),
    .init     (track_init),
    .en       (track_en),
    .first    (ptr == '0),
    .entry    (bus.mem_rdata),
    .best_id  (bus.best_id),
    .best_fit (bus.best_fit)
  );

endmodule

// File: doc/cand_bank_ctrl.md
Name: cand_bank_ctrl

Overview:
Controller that sequences the 16-bit candidate memory bank, which stores byte pairs at index and index+1. It manages a list of cluster-head candidates, one word per entry: {node_id[7:0], fitness[7:0]}. It handles appends, clears the list, and scans for the best-fitness candidate. It owns every bank write and is the only driver of the bank's index, wr_en and data_in.

Parameters:
MAX_CAND, 8, list capacity in entries; legal range 1..8; entry k lives at bank index 2k
CNT_W, 4, width of the count output; must hold MAX_CAND

Ports:
clk  in  1  rising-edge clock
nrst  in  1  asynchronous active-low reset
ins_valid  in  1  insert request
ins_ready  out  1  controller can accept an insert
ins_id  in  8  candidate node ID
ins_fit  in  8  candidate fitness
ins_drop  out  1  1-cycle pulse: insert discarded (only with dedup feature; else tied 0)
scan_start  in  1  request best-candidate scan
scan_busy  out  1  high while scanning
scan_done  out  1  1-cycle pulse at scan completion
best_valid  out  1  best_id/best_fit hold a valid result
best_id  out  8  ID of best candidate
best_fit  out  8  fitness of best candidate
clear  in  1  empty the list
count  out  CNT_W  number of stored entries
full  out  1  count == MAX_CAND
empty  out  1  count == 0
mem_wr_en  out  1  to bank wr_en
mem_index  out  4  to bank index; always even
mem_wdata  out  16  to bank data_in
mem_rdata  in  16  from bank data_out (combinational read)

Behaviour:
- Reset values: state IDLE; count=0; best_valid, best_id, best_fit, scan_busy, scan_done, ins_drop, mem_wr_en = 0; mem_index=0; mem_wdata=0.
- After reset, ins_ready=1 and empty=1.
- States: IDLE, WRITE, SCAN, DONE; with dedup enabled, LOOKUP is added.
- ins_ready = (state==IDLE) && !full && !clear && !scan_start.
- IDLE priority when several requests arrive together: clear > scan_start > insert.
- Insert:
  - The handshake completes when ins_valid && ins_ready; id and fit are latched on that edge.
  - WRITE (1 cycle): mem_wr_en=1, mem_index=2*count, mem_wdata={id,fit}.
  - At the end of WRITE, count increments and the FSM returns to IDLE.
  - Sustained throughput is one insert per 2 cycles.
  - Any accepted insert clears best_valid.
- Scan:
  - scan_start in IDLE with count>0 enters SCAN with ptr=0 and best_fit=0.
  - Each SCAN cycle: mem_index=2*ptr. If mem_rdata[7:0] > best_fit, or ptr==0, capture best_id/best_fit from mem_rdata.
  - The comparison is strict, so on ties the lower index wins.
  - After ptr==count-1, go to DONE: scan_done=1 for 1 cycle, best_valid=1, then return to IDLE.
  - Latency from scan_start to scan_done is count+1 cycles.
  - scan_start with count==0: go straight to DONE; scan_done pulses, best_valid stays 0.
  - scan_start outside IDLE is ignored.
- Clear:
  - Sampled in every state and aborts any operation. Next state IDLE, count=0, best_valid=0.
  - mem_wr_en is forced 0 combinationally in any cycle where clear=1.
  - Bank contents are not erased.
- Full: ins_ready=0; ins_valid has no effect.
- Reset mid-operation returns everything to reset values immediately (asynchronous).
- mem_index never exceeds 2*(MAX_CAND-1), so index+1 never wraps.

Optional Feature:
CAND_DEDUP_EN
- Defined:
  - ins_ready drops the !full term.
  - An accepted insert enters LOOKUP, which reads entries 0..count-1, one per cycle.
  - On the first ID match, WRITE overwrites that entry; count is unchanged.
  - With no match and not full, the entry is appended.
  - With no match and full, nothing is written, ins_drop pulses 1 cycle, and the FSM returns to IDLE.
  - With count==0, LOOKUP takes 1 cycle, then append.
- Undefined: LOOKUP is absent and ins_drop is constant 0.

Decomposition:
- Shared package cand_pkg:
  - state encodings
  - field constants ID_MSB=15, ID_LSB=8, FIT_MSB=7, FIT_LSB=0
  - entry stride 2
  - default MAX_CAND
- One natural sub-module: cand_max_track, the running-max register with strict-greater compare, load on ptr==0, clear/reset.

Test Plan:
- Reset, then insert (0x11,0x40), (0x22,0x90), (0x33,0x90) -> bank bytes 0..5 = 11 40 22 90 33 90; count=3; each insert shows mem_wr_en high for exactly 1 cycle.
- Scan on that list -> scan_busy for 3 cycles, scan_done 4 cycles after scan_start, best_id=0x22 and best_fit=0x90 (tie keeps lower index), best_valid=1.
- Fill to 8 entries -> full=1, ins_ready=0; a 9th ins_valid held 5 cycles -> no write, count stays 8.
- Assert clear during SCAN of 8 entries -> next cycle IDLE, count=0, best_valid=0, no scan_done pulse; scan_start on the empty list -> scan_done next cycle with best_valid=0.
- clear and scan_start and ins_valid asserted in the same IDLE cycle -> only the clear takes effect, no mem_wr_en.
- With CAND_DEDUP_EN: insert (0x22,0x10) into the list above -> entry 1 rewritten to 22 10, count unchanged. On a full list, new ID 0x99 -> ins_drop pulses, no write.
